// File: rtl/coinc_pkg.sv
`default_nettype none
// ============================================================================
// Package : coinc_pkg
// Brief   : Shared mode encodings, LFSR constants and FSM state type for the
//           coincidence datapath blocks.
// Rev     : 1.0  initial release
// ============================================================================
package coinc_pkg;

    localparam logic [1:0] MODE_FIXED = 2'd0;
    localparam logic [1:0] MODE_RR    = 2'd1;
    localparam logic [1:0] MODE_SHUF  = 2'd2;
    localparam logic [1:0] MODE_RAND  = 2'd3;

    // x^16+x^14+x^13+x^11+1 as a right-shifting Galois tap mask
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } shuf_state_t;

endpackage : coinc_pkg
`default_nettype wire

// File: rtl/lfsr_galois.sv
`default_nettype none
// ============================================================================
// Module  : lfsr_galois
// Brief   : Right-shifting Galois LFSR that advances while en is high.
// Rev     : 1.0  initial release
// ============================================================================
module lfsr_galois
    import coinc_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    // An all-zero state would lock the register up.
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;

    always_comb begin
        w_q_nxt = {1'b0, r_q[WIDTH-1:1]} ^ (r_q[0] ? TAPS : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= SEED_EFF;
        end else if (en) begin
            r_q <= w_q_nxt;
        end
    end

    assign q = r_q;

endmodule : lfsr_galois
`default_nettype wire

// File: rtl/output_shuffle_param.sv
`default_nettype none
// ============================================================================
// Module  : output_shuffle_param
// Brief   : One-hot channel sequencer with fixed, round-robin, permuted and
//           random ordering, programmable dwell and round-complete pulse.
// Rev     : 1.0  initial release
// ============================================================================
module output_shuffle_param
    import coinc_pkg::*;
#(
    parameter int                NUM_CH  = 4,
    parameter int                DWELL_W = 16,
    parameter int                LFSR_W  = 16,
    parameter logic [LFSR_W-1:0] SEED    = LFSR_W'(DEFAULT_SEED),
    localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [CH_W-1:0]    fixed_ch,
    input  logic [DWELL_W-1:0] dwell,
    output logic [NUM_CH-1:0]  selection,
    output logic [CH_W-1:0]    sel_index,
    output logic               sel_valid,
    output logic               round_done
);

    shuf_state_t        r_state, w_state_nxt;
    logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
    logic [DWELL_W-1:0] r_lim, w_lim_nxt;
    logic [NUM_CH-1:0]  r_mask, w_mask_nxt;
    logic [1:0]         r_mode, w_mode_nxt;
    logic [CH_W-1:0]    r_idx, w_idx_nxt;
    logic [NUM_CH-1:0]  r_sel, w_sel_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_rd, w_rd_nxt;

    logic [LFSR_W-1:0]  w_lfsr;
    logic [CH_W-1:0]    w_cand;
    logic [CH_W-1:0]    w_fixed;
    logic [CH_W-1:0]    w_pick;
    logic [NUM_CH-1:0]  w_eff_mask;
    logic [NUM_CH-1:0]  w_shuf_mask;
    logic [DWELL_W-1:0] w_dwell_eff;
    logic               w_restart;
    logic               w_switch;

    lfsr_galois #(
        .WIDTH (LFSR_W),
        .TAPS  (LFSR_W'(LFSR_TAPS)),
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (enable),
        .q     (w_lfsr)
    );

    // First free channel at or after cand, wrapping around the channel ring.
    function automatic logic [CH_W-1:0] f_pick(input logic [NUM_CH-1:0] mask,
                                               input logic [CH_W-1:0]   cand);
        logic [CH_W-1:0] pick;
        logic            found;
        int              j;
        pick  = cand;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = int'(cand) + i;
            if (j >= NUM_CH) begin
                j = j - NUM_CH;
            end
            if (!found && !mask[CH_W'(j)]) begin
                pick  = CH_W'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_cand      = CH_W'(w_lfsr % LFSR_W'(NUM_CH));
    assign w_fixed     = ({1'b0, fixed_ch} >= (CH_W+1)'(NUM_CH)) ? CH_W'(NUM_CH-1) : fixed_ch;
    assign w_dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign w_restart   = (r_state == ST_IDLE) || (mode != r_mode);
    assign w_switch    = (r_state == ST_IDLE) || (r_cnt >= r_lim);
    // A full mask is kept until the next switch so round_done lines up with the last pick.
    assign w_eff_mask  = (w_restart || (&r_mask)) ? '0 : r_mask;
    assign w_pick      = f_pick(w_eff_mask, w_cand);
    assign w_shuf_mask = w_eff_mask | (NUM_CH'(1) << w_pick);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lim_nxt   = r_lim;
        w_mask_nxt  = r_mask;
        w_mode_nxt  = r_mode;
        w_idx_nxt   = r_idx;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_valid;
        w_rd_nxt    = 1'b0;

        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_mask_nxt  = '0;
            w_idx_nxt   = '0;
            w_sel_nxt   = '0;
            w_valid_nxt = 1'b0;
        end else if (w_switch) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = DWELL_W'(1);
            w_lim_nxt   = w_dwell_eff;
            w_mode_nxt  = mode;
            w_valid_nxt = 1'b1;
            w_mask_nxt  = '0;
            case (mode)
                MODE_FIXED: begin
                    w_idx_nxt = w_fixed;
                end
                MODE_RR: begin
                    if (w_restart) begin
                        w_idx_nxt = '0;
                    end else if (r_idx == CH_W'(NUM_CH-1)) begin
                        w_idx_nxt = '0;
                        w_rd_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
                MODE_SHUF: begin
                    w_idx_nxt  = w_pick;
                    w_mask_nxt = w_shuf_mask;
                    w_rd_nxt   = &w_shuf_mask;
                end
                default: begin
                    w_idx_nxt = w_cand;
                end
            endcase
            w_sel_nxt = NUM_CH'(1) << w_idx_nxt;
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_lim   <= '0;
            r_mask  <= '0;
            r_mode  <= MODE_FIXED;
            r_idx   <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_rd    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lim   <= w_lim_nxt;
            r_mask  <= w_mask_nxt;
            r_mode  <= w_mode_nxt;
            r_idx   <= w_idx_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= w_valid_nxt;
            r_rd    <= w_rd_nxt;
        end
    end

    assign selection  = r_sel;
    assign sel_index  = r_idx;
    assign sel_valid  = r_valid;
    assign round_done = r_rd;

endmodule : output_shuffle_param
`default_nettype wire
